// File: rtl/serial_pkg.sv
// Shared types and constants for the serial receive FIFO and its XON/XOFF flow control.
package serial_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SEND_XOFF = 2'd1,
        HOLD      = 2'd2,
        SEND_XON  = 2'd3
    } flow_state_t;

    localparam byte_t XON_DEFAULT  = 8'h11;
    localparam byte_t XOFF_DEFAULT = 8'h13;

    // Tx holding register payload; flow marks a flow-control character versus an echoed byte.
    typedef struct packed {
        logic  flow;
        byte_t data;
    } tx_word_t;

endpackage

// File: rtl/serial_rx_fifo_byte_fifo.sv
// First-word-fall-through byte FIFO with a registered head byte, occupancy level and drop detection.
module byte_fifo
    import serial_pkg::*;
#(
    parameter  int unsigned DEPTH = 64,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  byte_t         wr_data,
    input  logic          rd_en,
    output byte_t         rd_data,
    output logic          valid,
    output logic [LW-1:0] level,
    output logic          push_c,
    output logic          drop_c
);

    byte_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_n;
    logic [AW-1:0] rd_ptr_n;
    logic [LW-1:0] level_n;
    logic [LW-1:0] level_after_pop;
    logic          pop;
    logic          full;
    byte_t         head_n;

    // Accept/drop decision and the head byte the output register will show next cycle.
    always_comb begin
        full            = (level == LW'(DEPTH));
        pop             = valid & rd_en;
        push_c          = wr_en & (~full | pop);
        drop_c          = wr_en & full & ~pop;
        rd_ptr_n        = rd_ptr + AW'(pop);
        wr_ptr_n        = wr_ptr + AW'(push_c);
        level_after_pop = level - LW'(pop);
        level_n         = level_after_pop + LW'(push_c);
        head_n          = rd_data;
        if (push_c && (level_after_pop == '0)) begin
            head_n = wr_data;
        end else if (level_n != '0) begin
            head_n = mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
            valid   <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            level   <= level_n;
            rd_data <= head_n;
            valid   <= (level_n != '0);
        end
    end

endmodule

// File: rtl/serial_rx_fifo.sv
// UART receive buffer with XON/XOFF flow control toward the host transmitter.
// Define SERIAL_RX_FIFO_ECHO_EN to also echo accepted bytes on the tx port below flow-char priority.
module serial_rx_fifo
    import serial_pkg::*;
#(
    parameter  int unsigned DEPTH     = 64,
    parameter  int unsigned HI_WM     = 48,
    parameter  int unsigned LO_WM     = 16,
    parameter  byte_t       XON_CHAR  = XON_DEFAULT,
    parameter  byte_t       XOFF_CHAR = XOFF_DEFAULT,
    localparam int unsigned LW        = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    output logic [7:0]    o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [7:0]    o_tx_data,
    output logic          o_tx_valid,
    input  logic          i_tx_ready,
    output logic [LW-1:0] o_level,
    output logic          o_overflow,
    input  logic          i_clr_overflow
);

    flow_state_t   state_q;
    flow_state_t   state_n;
    logic          flow_loaded_q;
    logic          flow_loaded_n;
    tx_word_t      tx_q;
    tx_word_t      tx_n;
    logic          tx_valid_q;
    logic          tx_valid_n;
    logic          tx_fire;
    logic          flow_done;
    logic          can_load;
    logic          overflow_q;
    logic [LW-1:0] level;
    logic          push;
    logic          drop;
`ifdef SERIAL_RX_FIFO_ECHO_EN
    byte_t         echo_data_q;
    byte_t         echo_data_n;
    logic          echo_valid_q;
    logic          echo_valid_n;
`endif

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .wr_en   (i_rx_valid),
        .wr_data (i_rx_data),
        .rd_en   (i_ready),
        .rd_data (o_data),
        .valid   (o_valid),
        .level   (level),
        .push_c  (push),
        .drop_c  (drop)
    );

    // Flow FSM next state and tx register load; each SEND state loads its character exactly once.
    always_comb begin
        state_n       = state_q;
        flow_loaded_n = flow_loaded_q;
        tx_n          = tx_q;
        tx_valid_n    = tx_valid_q & ~i_tx_ready;
        tx_fire       = tx_valid_q & i_tx_ready;
        flow_done     = tx_fire & tx_q.flow;
        can_load      = ~tx_valid_q | i_tx_ready;
`ifdef SERIAL_RX_FIFO_ECHO_EN
        echo_valid_n  = echo_valid_q;
        echo_data_n   = echo_data_q;
`endif

        case (state_q)
            RUN:       if (level >= LW'(HI_WM)) state_n = SEND_XOFF;
            SEND_XOFF: if (flow_done)           state_n = HOLD;
            HOLD:      if (level <= LW'(LO_WM)) state_n = SEND_XON;
            SEND_XON:  if (flow_done)           state_n = RUN;
            default:                            state_n = RUN;
        endcase

        if (can_load) begin
            if (((state_q == SEND_XOFF) || (state_q == SEND_XON)) && !flow_loaded_q) begin
                tx_n.flow     = 1'b1;
                tx_n.data     = (state_q == SEND_XOFF) ? XOFF_CHAR : XON_CHAR;
                tx_valid_n    = 1'b1;
                flow_loaded_n = 1'b1;
            end
`ifdef SERIAL_RX_FIFO_ECHO_EN
            else if (echo_valid_q) begin
                tx_n.flow    = 1'b0;
                tx_n.data    = echo_data_q;
                tx_valid_n   = 1'b1;
                echo_valid_n = 1'b0;
            end
`endif
        end

`ifdef SERIAL_RX_FIFO_ECHO_EN
        // A byte arriving while the echo slot is occupied is stored but not echoed.
        if (push && !echo_valid_q) begin
            echo_valid_n = 1'b1;
            echo_data_n  = i_rx_data;
        end
`endif

        if (state_n != state_q) begin
            flow_loaded_n = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= RUN;
            flow_loaded_q <= 1'b0;
            tx_q          <= '0;
            tx_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_n;
            flow_loaded_q <= flow_loaded_n;
            tx_q          <= tx_n;
            tx_valid_q    <= tx_valid_n;
        end
    end

`ifdef SERIAL_RX_FIFO_ECHO_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            echo_valid_q <= 1'b0;
            echo_data_q  <= '0;
        end else begin
            echo_valid_q <= echo_valid_n;
            echo_data_q  <= echo_data_n;
        end
    end
`endif

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end else if (i_clr_overflow) begin
            overflow_q <= 1'b0;
        end
    end

    assign o_tx_data  = tx_q.data;
    assign o_tx_valid = tx_valid_q;
    assign o_level    = level;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed self-checking bench for serial_rx_fifo (default DEPTH 64, HI_WM 48, LO_WM 16).
module tb_serial_rx_fifo;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic [6:0] o_level;
    logic       o_overflow;
    logic       i_clr_overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] txq[$];
    logic [7:0] popq[$];

    serial_rx_fifo dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rx_data      (i_rx_data),
        .i_rx_valid     (i_rx_valid),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_tx_data      (o_tx_data),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .o_level        (o_level),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow)
    );

    always #5 i_clk = ~i_clk;

    // Handshakes observed mid-cycle, where inputs and outputs are settled.
    always @(negedge i_clk) begin
        if (i_rst_n && o_tx_valid && i_tx_ready) txq.push_back(o_tx_data);
        if (i_rst_n && o_valid && i_ready)       popq.push_back(o_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic push_seq(input logic [7:0] base, input int n);
        i_rx_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            i_rx_data = base + 8'(i);
            step();
        end
        i_rx_valid = 1'b0;
    endtask

    function automatic int count_of(input logic [7:0] c);
        int n = 0;
        foreach (txq[i]) if (txq[i] == c) n++;
        return n;
    endfunction

    function automatic logic [7:0] first_flow();
        foreach (txq[i]) if (txq[i] == 8'h11 || txq[i] == 8'h13) return txq[i];
        return 8'h00;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit held_ok;
        i_rst_n = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0; i_ready = 1'b0;
        i_tx_ready = 1'b1; i_clr_overflow = 1'b0;
        step(3);
        check("rst_valid",    32'(o_valid),    0);
        check("rst_tx_valid", 32'(o_tx_valid), 0);
        check("rst_level",    32'(o_level),    0);
        check("rst_overflow", 32'(o_overflow), 0);
        check("rst_data",     32'(o_data),     0);
        check("rst_tx_data",  32'(o_tx_data),  0);
        i_rst_n = 1'b1;
        step(2);

        // Basic FWFT ordering.
        i_rx_valid = 1'b1; i_rx_data = 8'h41;
        step();
        check("fwft_valid", 32'(o_valid), 1);
        check("fwft_data",  32'(o_data),  32'h41);
        push_seq(8'h42, 2);
        check("fwft_level3", 32'(o_level), 3);
        check("fwft_head",   32'(o_data),  32'h41);
        i_ready = 1'b1;
        step(3);
        i_ready = 1'b0;
        check("fwft_pops", 32'(popq.size()), 3);
        check("fwft_pop0", 32'(popq[0]), 32'h41);
        check("fwft_pop1", 32'(popq[1]), 32'h42);
        check("fwft_pop2", 32'(popq[2]), 32'h43);
        check("fwft_level0", 32'(o_level), 0);
        check("fwft_empty",  32'(o_valid), 0);

        // XOFF at high watermark, XON at low watermark, once each.
        txq.delete(); popq.delete();
        push_seq(8'h20, 48);
        step(6);
        check("wm_level48", 32'(o_level), 48);
        check("wm_xoff1",   32'(count_of(8'h13)), 1);
        check("wm_xon0",    32'(count_of(8'h11)), 0);
        i_ready = 1'b1;
        step(32);
        i_ready = 1'b0;
        step(8);
        check("wm_level16", 32'(o_level), 16);
        check("wm_popcnt",  32'(popq.size()), 32);
        check("wm_pop0",    32'(popq[0]), 32'h20);
        check("wm_xon1",    32'(count_of(8'h11)), 1);
        step(10);
        check("wm_xoff_once", 32'(count_of(8'h13)), 1);
        check("wm_xon_once",  32'(count_of(8'h11)), 1);
        i_ready = 1'b1;
        step(16);
        i_ready = 1'b0;
        check("wm_drained", 32'(o_level), 0);

        // Overflow on full, push+pop at full, clear, drop-wins-over-clear.
        push_seq(8'h80, 64);
        check("ovf_full",   32'(o_level),    64);
        check("ovf_none",   32'(o_overflow), 0);
        push_seq(8'h55, 1);
        check("ovf_set",    32'(o_overflow), 1);
        check("ovf_level",  32'(o_level),    64);
        i_clr_overflow = 1'b1; step(); i_clr_overflow = 1'b0;
        check("ovf_clr",    32'(o_overflow), 0);
        i_rx_valid = 1'b1; i_rx_data = 8'h56; i_ready = 1'b1;
        step();
        i_rx_valid = 1'b0; i_ready = 1'b0;
        check("pp_level",   32'(o_level),    64);
        check("pp_noovf",   32'(o_overflow), 0);
        check("pp_head",    32'(o_data),     32'h81);
        i_rx_valid = 1'b1; i_rx_data = 8'h57; i_clr_overflow = 1'b1;
        step();
        i_rx_valid = 1'b0;
        check("drop_wins",  32'(o_overflow), 1);
        step();
        i_clr_overflow = 1'b0;
        check("ovf_clr2",   32'(o_overflow), 0);
        popq.delete();
        i_ready = 1'b1;
        step(64);
        i_ready = 1'b0;
        check("ovf_popcnt", 32'(popq.size()), 64);
        check("ovf_first",  32'(popq[0]),  32'h81);
        check("ovf_last",   32'(popq[63]), 32'h56);
        check("ovf_empty",  32'(o_level),  0);
        step(4);

        // XOFF held stable under tx backpressure while draining, then XON follows.
        push_seq(8'h20, 48);
        for (int i = 0; i < 20; i++) begin
            if (o_tx_valid && o_tx_data == 8'h13) break;
            i_tx_ready = o_tx_valid && (o_tx_data != 8'h13);
            step();
        end
        i_tx_ready = 1'b0;
        check("bp_xoff_valid", 32'(o_tx_valid), 1);
        check("bp_xoff_data",  32'(o_tx_data),  32'h13);
        txq.delete();
        held_ok = 1'b1;
        i_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!(o_tx_valid && o_tx_data == 8'h13)) held_ok = 1'b0;
        end
        i_ready = 1'b0;
        step(2);
        if (!(o_tx_valid && o_tx_data == 8'h13)) held_ok = 1'b0;
        check("bp_held",   32'(held_ok), 1);
        check("bp_level8", 32'(o_level), 8);
        i_tx_ready = 1'b1;
        step(8);
        check("bp_xoff1",  32'(count_of(8'h13)), 1);
        check("bp_xon1",   32'(count_of(8'h11)), 1);
        check("bp_order",  32'(first_flow()), 32'h13);
        i_ready = 1'b1;
        step(8);
        i_ready = 1'b0;
        step(2);

        // Reset with data queued and a tx request pending.
        i_tx_ready = 1'b0;
        push_seq(8'h30, 48);
        step(4);
        check("mr_tx_pending", 32'(o_tx_valid), 1);
        i_ready = 1'b1;
        step(38);
        i_ready = 1'b0;
        check("mr_level10", 32'(o_level), 10);
        #2 i_rst_n = 1'b0;
        #1;
        check("mr_valid",    32'(o_valid),    0);
        check("mr_tx_valid", 32'(o_tx_valid), 0);
        check("mr_level",    32'(o_level),    0);
        check("mr_overflow", 32'(o_overflow), 0);
        step(2);
        i_rst_n = 1'b1;
        i_tx_ready = 1'b1;
        step();
        txq.delete();
        push_seq(8'h77, 1);
        check("mr_push_valid", 32'(o_valid), 1);
        check("mr_push_data",  32'(o_data),  32'h77);
        check("mr_push_level", 32'(o_level), 1);
        step(6);
        check("mr_no_flow", 32'(count_of(8'h11) + count_of(8'h13)), 0);
        i_ready = 1'b1;
        step();
        i_ready = 1'b0;
        step(2);

`ifdef SERIAL_RX_FIFO_ECHO_EN
        // Echo path, busy-slot suppression, and flow-char priority over echo.
        txq.delete();
        push_seq(8'h61, 1);
        step(4);
        check("echo_cnt",  32'(txq.size()), 1);
        check("echo_0x61", 32'(txq[0]), 32'h61);
        i_tx_ready = 1'b0;
        txq.delete();
        push_seq(8'h62, 2);
        step(3);
        i_tx_ready = 1'b1;
        step(4);
        check("echo_busy_cnt", 32'(txq.size()), 1);
        check("echo_busy_b0",  32'(txq[0]), 32'h62);
        i_ready = 1'b1;
        step(6);
        i_ready = 1'b0;
        check("echo_drained", 32'(o_level), 0);
        i_tx_ready = 1'b0;
        txq.delete();
        push_seq(8'h20, 48);
        step(4);
        i_tx_ready = 1'b1;
        step(5);
        check("prio_cnt", 32'(txq.size()), 3);
        check("prio_0",   32'(txq[0]), 32'h20);
        check("prio_1",   32'(txq[1]), 32'h13);
        check("prio_2",   32'(txq[2]), 32'h22);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
